address_mux_scheduler: RTL and testbench

ADDRESS_MUX_SCHEDULER -- requirements
Module: address_mux_scheduler

---
 rtl/address_mux_scheduler_if.sv | 24 ++
 rtl/address_mux_scheduler.sv | 92 +++++++++
 tb/tb_address_mux_scheduler.sv | 117 +++++++++++
 3 files changed

// File: rtl/address_mux_scheduler_if.sv
// address_mux_scheduler_if: request/burst/stall inputs and mux-select/grant outputs of the scheduler
interface address_mux_scheduler_if #(
    parameter int BURST_W = 8
);
    logic [2:0]         req;
    logic [BURST_W-1:0] len0;
    logic [BURST_W-1:0] len1;
    logic [BURST_W-1:0] len2;
    logic               stall;
    logic [1:0]         sel;
    logic [2:0]         gnt;
    logic               beat_valid;
    logic [BURST_W-1:0] beat_cnt;
    logic [2:0]         burst_done;
    logic               busy;
    modport master (
        output req, len0, len1, len2, stall,
        input  sel, gnt, beat_valid, beat_cnt, burst_done, busy
    );
    modport slave (
        input  req, len0, len1, len2, stall,
        output sel, gnt, beat_valid, beat_cnt, burst_done, busy
    );
endinterface

// File: rtl/address_mux_scheduler.sv
// address_mux_scheduler: round-robin burst scheduler driving a 3-source address mux select
module address_mux_scheduler #(
    parameter int BURST_W    = 8,
    parameter int array_size = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    address_mux_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    if (array_size < 1) begin : g_bad_array_size
        $error("array_size must be at least 1");
    end

    logic [1:0]         state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         last_q, last_d;
    logic [2:0]         gnt_q, gnt_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [1:0]         c0, c1, win;
    logic [BURST_W-1:0] win_len;
    logic               last_beat, bv;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // search order starts just after the last winner; the last winner itself is tried last
    assign c0        = nxt(last_q);
    assign c1        = nxt(c0);
    assign win       = bus.req[c0] ? c0 : bus.req[c1] ? c1 : last_q;
    assign win_len   = (win == 2'd0) ? bus.len0 : (win == 2'd1) ? bus.len1 : bus.len2;
    assign last_beat = (cnt_q == len_q - BURST_W'(1));
    assign bv        = (state_q == BURST) & ~bus.stall;

    assign bus.sel        = sel_q;
    assign bus.gnt        = gnt_q;
    assign bus.beat_cnt   = cnt_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.beat_valid = bv;
    assign bus.burst_done = gnt_q & {3{bv & last_beat}};

    // grant in IDLE, advance beats while unstalled, single GAP cycle after each burst
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        last_d  = last_q;
        if (state_q == IDLE && |bus.req) begin
            state_d = BURST;
            sel_d   = win;
            gnt_d   = 3'b001 << win;
            len_d   = (win_len == '0) ? BURST_W'(1) : win_len;
            last_d  = win;
            cnt_d   = '0;
        end else if (state_q == BURST && !bus.stall) begin
            cnt_d   = last_beat ? '0 : cnt_q + BURST_W'(1);
            state_d = last_beat ? GAP : BURST;
            sel_d   = last_beat ? 2'b11 : sel_q;
            gnt_d   = last_beat ? 3'b000 : gnt_q;
        end else if (state_q != IDLE && state_q != BURST) begin
            state_d = IDLE;
            sel_d   = 2'b11;
            gnt_d   = 3'b000;
        end
    end

    // state registers; reset abandons any burst and gives requester 0 top priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 2'b11;
            gnt_q   <= 3'b000;
            cnt_q   <= '0;
            len_q   <= BURST_W'(1);
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_address_mux_scheduler.sv
// tb_address_mux_scheduler: directed checks of arbitration, bursts, stalls and reset
module tb_address_mux_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    address_mux_scheduler_if #(.BURST_W(8)) bus ();
    address_mux_scheduler #(.BURST_W(8), .array_size(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        chk("inv_gnt_onehot0", 32'($countones(bus.gnt) <= 1), 32'd1);
        chk("inv_sel_gnt", 32'(((bus.sel == 2'b11) == (bus.gnt == 3'b000)) &&
            (bus.gnt == 3'b000 || bus.gnt == (3'b001 << bus.sel))), 32'd1);
        chk("inv_bv_burst", 32'(!bus.beat_valid || (bus.busy && bus.gnt != 3'b000)), 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [1:0] s, input logic [2:0] g,
                              input logic v, input logic [7:0] c, input logic [2:0] d,
                              input logic b);
        #1;
        chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".beat_valid"}, 32'(bus.beat_valid), 32'(v));
        chk({tag, ".beat_cnt"}, 32'(bus.beat_cnt), 32'(c));
        chk({tag, ".burst_done"}, 32'(bus.burst_done), 32'(d));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    endtask

    initial begin
        bus.req = 3'b000; bus.len0 = 8'd2; bus.len1 = 8'd2; bus.len2 = 8'd2; bus.stall = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        expect_out("reset", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        // all three requesting, 2-beat bursts: order 0,1,2 with a GAP between
        bus.req = 3'b111;
        cyc(); expect_out("rr0_b0", 2'b00, 3'b001, 1, 0, 3'b000, 1);
        cyc(); expect_out("rr0_b1", 2'b00, 3'b001, 1, 1, 3'b001, 1);
        cyc(); expect_out("rr0_gap", 2'b11, 3'b000, 0, 0, 3'b000, 1);
        cyc(); expect_out("rr0_idle", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        cyc(); expect_out("rr1_b0", 2'b01, 3'b010, 1, 0, 3'b000, 1);
        cyc(); expect_out("rr1_b1", 2'b01, 3'b010, 1, 1, 3'b010, 1);
        cyc(); expect_out("rr1_gap", 2'b11, 3'b000, 0, 0, 3'b000, 1);
        cyc(); expect_out("rr1_idle", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        cyc(); expect_out("rr2_b0", 2'b10, 3'b100, 1, 0, 3'b000, 1);
        cyc(); expect_out("rr2_b1", 2'b10, 3'b100, 1, 1, 3'b100, 1);
        cyc(); expect_out("rr2_gap", 2'b11, 3'b000, 0, 0, 3'b000, 1);
        bus.req = 3'b000;
        cyc(); expect_out("rr2_idle", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        // requester 1, 4 beats, stalls of 2 cycles on beats 1 and 2
        bus.req = 3'b010; bus.len1 = 8'd4;
        cyc(); bus.req = 3'b000;
        expect_out("st_c0", 2'b01, 3'b010, 1, 0, 3'b000, 1);
        cyc(); bus.stall = 1'b1; expect_out("st_c1a", 2'b01, 3'b010, 0, 1, 3'b000, 1);
        cyc(); expect_out("st_c1b", 2'b01, 3'b010, 0, 1, 3'b000, 1);
        cyc(); bus.stall = 1'b0; expect_out("st_c1c", 2'b01, 3'b010, 1, 1, 3'b000, 1);
        cyc(); bus.stall = 1'b1; expect_out("st_c2a", 2'b01, 3'b010, 0, 2, 3'b000, 1);
        cyc(); expect_out("st_c2b", 2'b01, 3'b010, 0, 2, 3'b000, 1);
        cyc(); bus.stall = 1'b0; expect_out("st_c2c", 2'b01, 3'b010, 1, 2, 3'b000, 1);
        cyc(); expect_out("st_c3", 2'b01, 3'b010, 1, 3, 3'b010, 1);
        cyc(); expect_out("st_gap", 2'b11, 3'b000, 0, 0, 3'b000, 1);
        cyc(); expect_out("st_idle", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        // len0 = 0 is a single beat; done only on the first unstalled cycle
        bus.len0 = 8'd0; bus.req = 3'b001; bus.stall = 1'b1;
        cyc(); expect_out("z_stall", 2'b00, 3'b001, 0, 0, 3'b000, 1);
        bus.stall = 1'b0; expect_out("z_beat", 2'b00, 3'b001, 1, 0, 3'b001, 1);
        cyc(); bus.req = 3'b000; expect_out("z_gap", 2'b11, 3'b000, 0, 0, 3'b000, 1);
        cyc(); expect_out("z_idle", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        // requester 2 drops req after grant; the 5-beat burst still completes
        bus.req = 3'b100; bus.len2 = 8'd5;
        cyc();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) bus.req = 3'b000;
            expect_out($sformatf("drop_b%0d", i), 2'b10, 3'b100, 1, 8'(i),
                       (i == 4) ? 3'b100 : 3'b000, 1);
            cyc();
        end
        expect_out("drop_gap", 2'b11, 3'b000, 0, 0, 3'b000, 1);
        cyc(); expect_out("drop_idle", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        // reset at beat 3 of an 8-beat burst from requester 1
        bus.req = 3'b010; bus.len1 = 8'd8;
        cyc(); expect_out("rst_b0", 2'b01, 3'b010, 1, 0, 3'b000, 1);
        cyc(); cyc(); cyc();
        expect_out("rst_b3", 2'b01, 3'b010, 1, 3, 3'b000, 1);
        reset = 1'b1; bus.req = 3'b000;
        cyc(); expect_out("rst_hold", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        reset = 1'b0; bus.req = 3'b011;
        expect_out("rst_idle", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        cyc(); expect_out("rst_g0", 2'b00, 3'b001, 1, 0, 3'b001, 1);
        cyc(); expect_out("rst_g0_gap", 2'b11, 3'b000, 0, 0, 3'b000, 1);
        cyc(); expect_out("rst_g0_idle", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        cyc(); expect_out("rst_g1", 2'b01, 3'b010, 1, 0, 3'b000, 1);
        // last_granted = 1 here; after reset req=110 must pick 1, not 2
        reset = 1'b1; bus.req = 3'b110;
        cyc(); reset = 1'b0;
        expect_out("prio_idle", 2'b11, 3'b000, 0, 0, 3'b000, 0);
        cyc(); expect_out("prio_g1", 2'b01, 3'b010, 1, 0, 3'b000, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
